counter_sequence_checker: RTL

COUNTER_SEQUENCE_CHECKER -- requirements
Module: counter_sequence_checker

---
 rtl/counter_check_pkg.sv | 23 ++
 rtl/sat_counter.sv | 36 +++
 rtl/counter_sequence_checker.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/counter_check_pkg.sv
// -----------------------------------------------------------------------------
// counter_check_pkg
// Shared definitions for the counter sequence checker: the FSM state encoding,
// the width of the internal match/miss counters and the default lock/unlock
// thresholds used as parameter defaults by the top level.
// -----------------------------------------------------------------------------
package counter_check_pkg;

    // State encoding is visible on o_State, so the values are fixed.
    typedef enum logic [1:0] {
        ST_SEARCH   = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_DEGRADED = 2'd3
    } state_t;

    localparam int SAMPLE_W         = 4;  // width of the counter samples
    localparam int RUN_W            = 4;  // match/miss counters, thresholds up to 15
    localparam int DEF_LOCK_COUNT   = 4;
    localparam int DEF_UNLOCK_COUNT = 3;
    localparam int DEF_ERR_WIDTH    = 8;

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear. A clear that coincides with an
// increment loads 1, so the event seen on the clearing edge is not lost.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset, forces count to 0
//   clear  - synchronous clear
//   inc    - increment request (ignored once the counter is at its maximum)
//   count  - current count, WIDTH bits
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= inc ? ONE : '0;
        end else if (inc && (count != MAX_VAL)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/counter_sequence_checker.sv
// -----------------------------------------------------------------------------
// counter_sequence_checker
// Tracks samples from a free-running 4-bit up-counter. It acquires lock after
// LOCK_COUNT consecutive in-sequence samples, then flywheels the expected value
// and counts mismatches. UNLOCK_COUNT consecutive mismatches drop lock and the
// checker goes back to searching.
//
// Ports:
//   i_Clock      - clock, rising edge
//   i_Reset      - asynchronous active-high reset
//   i_Valid      - i_Data holds a sample this cycle
//   i_Data       - 4-bit counter sample
//   i_Clear      - synchronous clear of the error counter
//   o_Locked     - high in LOCKED or DEGRADED
//   o_State      - current state (SEARCH=0, ACQUIRE=1, LOCKED=2, DEGRADED=3)
//   o_Expected   - value the next valid sample must equal
//   o_Error      - one-cycle pulse per counted mismatch
//   o_ErrorCount - saturating mismatch count, ERR_WIDTH bits
// -----------------------------------------------------------------------------
module counter_sequence_checker
    import counter_check_pkg::*;
#(
    parameter int LOCK_COUNT   = DEF_LOCK_COUNT,
    parameter int UNLOCK_COUNT = DEF_UNLOCK_COUNT,
    parameter int ERR_WIDTH    = DEF_ERR_WIDTH
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Valid,
    input  logic [SAMPLE_W-1:0]  i_Data,
    input  logic                 i_Clear,
    output logic                 o_Locked,
    output logic [1:0]           o_State,
    output logic [SAMPLE_W-1:0]  o_Expected,
    output logic                 o_Error,
    output logic [ERR_WIDTH-1:0] o_ErrorCount
);

    localparam logic [RUN_W-1:0]    LOCK_CNT   = RUN_W'(LOCK_COUNT);
    localparam logic [RUN_W-1:0]    UNLOCK_CNT = RUN_W'(UNLOCK_COUNT);
    localparam logic [RUN_W-1:0]    RUN_ONE    = RUN_W'(1);
    localparam logic [SAMPLE_W-1:0] SAMPLE_ONE = SAMPLE_W'(1);

    state_t              state;
    state_t              state_nxt;
    logic [SAMPLE_W-1:0] expected;
    logic [SAMPLE_W-1:0] expected_nxt;
    logic [RUN_W-1:0]    match_cnt;
    logic [RUN_W-1:0]    match_nxt;
    logic [RUN_W-1:0]    miss_cnt;
    logic [RUN_W-1:0]    miss_nxt;
    logic                error_reg;
    logic                error_nxt;
    logic                hit;

    // Sample arithmetic is 4 bits wide, so 15 + 1 wraps to 0 naturally.
    assign hit = (i_Data == expected);

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state     <= ST_SEARCH;
            expected  <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            error_reg <= 1'b0;
        end else begin
            state     <= state_nxt;
            expected  <= expected_nxt;
            match_cnt <= match_nxt;
            miss_cnt  <= miss_nxt;
            error_reg <= error_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        expected_nxt = expected;
        match_nxt    = match_cnt;
        miss_nxt     = miss_cnt;
        error_nxt    = 1'b0;

        if (i_Valid) begin
            case (state)
                ST_SEARCH: begin
                    expected_nxt = i_Data + SAMPLE_ONE;
                    match_nxt    = RUN_ONE;
                    state_nxt    = ST_ACQUIRE;
                end

                ST_ACQUIRE: begin
                    // Before lock the source is trusted: always re-seed from
                    // the sample, and a mismatch just restarts the run.
                    expected_nxt = i_Data + SAMPLE_ONE;
                    if (hit) begin
                        match_nxt = match_cnt + RUN_ONE;
                        if ((match_cnt + RUN_ONE) == LOCK_CNT) begin
                            state_nxt = ST_LOCKED;
                        end
                    end else begin
                        match_nxt = RUN_ONE;
                    end
                end

                ST_LOCKED: begin
                    // Flywheel: once locked the expected value advances on its
                    // own and a bad sample never re-seeds it.
                    expected_nxt = expected + SAMPLE_ONE;
                    if (!hit) begin
                        error_nxt = 1'b1;
                        miss_nxt  = RUN_ONE;
                        state_nxt = (UNLOCK_CNT == RUN_ONE) ? ST_SEARCH : ST_DEGRADED;
                    end
                end

                ST_DEGRADED: begin
                    expected_nxt = expected + SAMPLE_ONE;
                    if (hit) begin
                        miss_nxt  = '0;
                        state_nxt = ST_LOCKED;
                    end else begin
                        error_nxt = 1'b1;
                        miss_nxt  = miss_cnt + RUN_ONE;
                        if ((miss_cnt + RUN_ONE) == UNLOCK_CNT) begin
                            state_nxt = ST_SEARCH;
                        end
                    end
                end

                default: begin
                    state_nxt = ST_SEARCH;
                end
            endcase
        end
    end

    // The counter increments on the same edge that raises o_Error, keeping the
    // pulse and the count aligned.
    sat_counter #(
        .WIDTH (ERR_WIDTH)
    ) u_err_cnt (
        .clk   (i_Clock),
        .rst   (i_Reset),
        .clear (i_Clear),
        .inc   (error_nxt),
        .count (o_ErrorCount)
    );

    assign o_State    = state;
    assign o_Locked   = (state == ST_LOCKED) || (state == ST_DEGRADED);
    assign o_Expected = expected;
    assign o_Error    = error_reg;

endmodule
